// File: rtl/bt_pipe_in_buffer.sv
// bt_pipe_in_buffer
//   Receive side of a block-throttled host-to-FPGA pipe, placed behind the
//   okBTPipeIn endpoint. Host writes arrive in fixed-size blocks, are buffered
//   in a circular RAM FIFO and presented to user logic as a first-word-fall-
//   through valid/ready stream. The host is throttled with ep_ready, which is
//   only raised when a whole block is guaranteed to fit.
//
// Parameters
//   BLOCK_WORDS  words per host block (power of 2, 2..2**DEPTH_LOG2)
//   DEPTH_LOG2   log2 of buffer depth in 32-bit words
//
// Ports
//   okClk           in   pipe clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   ep_write        in   endpoint write strobe, one word per cycle
//   ep_blockstrobe  in   one-cycle pulse preceding each block
//   ep_dataout      in   endpoint write data
//   ep_ready        out  room for one full block (registered)
//   out_data        out  stream data
//   out_valid       out  stream valid
//   out_ready       in   stream ready
//   level           out  words held (RAM plus output register)
//   err_clr         in   clears overflow and block_err
//   overflow        out  sticky: write dropped because buffer full
//   block_err       out  sticky: block framing violated
//   out_sob         out  (BT_PIPE_IN_BLOCK_TAG_EN only) first word of a block
//
// Build option
//   BT_PIPE_IN_BLOCK_TAG_EN: adds out_sob, carried as a 33rd FIFO bit.

module bt_pipe_in_buffer #(
  parameter int BLOCK_WORDS = 256,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic                  okClk,
  input  logic                  reset_n,
  input  logic                  ep_write,
  input  logic                  ep_blockstrobe,
  input  logic [31:0]           ep_dataout,
  output logic                  ep_ready,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  err_clr,
  output logic                  overflow,
`ifdef BT_PIPE_IN_BLOCK_TAG_EN
  output logic                  block_err,
  output logic                  out_sob
`else
  output logic                  block_err
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(BLOCK_WORDS) + 1;
`ifdef BT_PIPE_IN_BLOCK_TAG_EN
  localparam int W     = 33;
`else
  localparam int W     = 32;
`endif
  // Highest level at which another full block still fits.
  localparam logic [LW-1:0] READY_MAX = LW'(DEPTH - BLOCK_WORDS);

  typedef enum logic {IDLE, RECV} state_t;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [W-1:0]          out_word_reg;
  logic [CW-1:0]         word_cnt_reg, word_cnt_next;
  state_t                state_reg, state_next;
  logic [LW-1:0]         level_next, ram_cnt;
  logic                  push, drop, pop, load, out_valid_next;
  logic                  overflow_next, block_err_next, ep_ready_next;
  logic [W-1:0]          wr_word;

  // level never exceeds DEPTH, so its MSB alone flags "full".
  assign push    = ep_write & ~level[DEPTH_LOG2];
  assign drop    = ep_write &  level[DEPTH_LOG2];
  assign pop     = out_valid & out_ready;
  assign ram_cnt = level - LW'(out_valid);
  // Refill the output register whenever it is empty or being emptied.
  assign load    = (ram_cnt != '0) & (~out_valid | out_ready);

`ifdef BT_PIPE_IN_BLOCK_TAG_EN
  logic sob_pend_reg;
  // A strobe coinciding with the write tags that write directly.
  assign wr_word  = {ep_blockstrobe | sob_pend_reg, ep_dataout};
  assign out_data = out_word_reg[31:0];
  assign out_sob  = out_word_reg[32] & out_valid;

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n)            sob_pend_reg <= 1'b0;
    else if (ep_write)       sob_pend_reg <= 1'b0;
    else if (ep_blockstrobe) sob_pend_reg <= 1'b1;
  end
`else
  assign wr_word  = ep_dataout;
  assign out_data = out_word_reg;
`endif

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase

    out_valid_next = out_valid;
    if (load)     out_valid_next = 1'b1;
    else if (pop) out_valid_next = 1'b0;

    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    block_err_next = block_err & ~err_clr;
    overflow_next  = (overflow & ~err_clr) | drop;

    // Strobe is handled before a same-cycle write, which then counts as word 1.
    if (ep_blockstrobe) begin
      if (state_reg == RECV) block_err_next = 1'b1;
      state_next    = RECV;
      word_cnt_next = ep_write ? CW'(1) : '0;
    end else if (ep_write) begin
      if (state_reg == IDLE) begin
        block_err_next = 1'b1;
      end else if (word_cnt_reg + CW'(1) == CW'(BLOCK_WORDS)) begin
        state_next    = IDLE;
        word_cnt_next = '0;
      end else begin
        word_cnt_next = word_cnt_reg + CW'(1);
      end
    end

    // Evaluated on next-state values so ep_ready drops right after the strobe.
    ep_ready_next = (state_next == IDLE) && (level_next <= READY_MAX);
  end

  // RAM write port: no reset so the array maps onto block RAM.
  always_ff @(posedge okClk) begin
    if (push) mem[wr_ptr_reg] <= wr_word;
  end

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      out_word_reg <= '0;
      out_valid    <= 1'b0;
      level        <= '0;
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      overflow     <= 1'b0;
      block_err    <= 1'b0;
      ep_ready     <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      if (load) begin
        out_word_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      out_valid    <= out_valid_next;
      level        <= level_next;
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      overflow     <= overflow_next;
      block_err    <= block_err_next;
      ep_ready     <= ep_ready_next;
    end
  end

endmodule
